snow64_instr_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the instruction cache.
- Holds the program counter and issues single-cycle read requests to the cache.
- Waits through hits and misses, and presents each fetched instruction with its address to decode over a valid/ready handshake.
- Handles branch redirects, discarding any in-flight cache response that belongs to the old path.

---
 rtl/snow64_instr_fetch.sv | 140 ++++++++++++++
 tb/tb_snow64_instr_fetch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_instr_fetch.sv
// Instruction fetch stage sitting directly upstream of the instruction cache.
//
// Holds the program counter and issues single-cycle read requests to the cache.
// It then waits through the hit or miss and presents each fetched instruction,
// with its address, to decode over a valid/ready handshake. A branch or
// exception redirect retargets the PC. Any cache response still in flight for
// the old path is discarded when it arrives.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   out_icache_req      one-cycle read request to the cache
//   out_icache_addr     request address (always the current PC, instruction units)
//   in_icache_valid     cache result valid (hit, or end of miss)
//   in_icache_instr     cache result instruction
//   in_redirect_valid   redirect strobe (highest priority)
//   in_redirect_addr    redirect target
//   out_valid           instruction available to decode
//   out_instr, out_pc   fetched instruction and its address
//   in_ready            decode accepts this cycle
module snow64_instr_fetch #(
  parameter int unsigned            ADDR_WIDTH  = 64,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,

  output logic                    out_icache_req,
  output logic [ADDR_WIDTH-1:0]   out_icache_addr,
  input  logic                    in_icache_valid,
  input  logic [INSTR_WIDTH-1:0]  in_icache_instr,

  input  logic                    in_redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   in_redirect_addr,

  output logic                    out_valid,
  output logic [INSTR_WIDTH-1:0]  out_instr,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  input  logic                    in_ready
);

  typedef enum logic [0:0] {
    StIssue,
    StWait
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
  logic                     discard_q, discard_d;
  logic                     out_valid_q, out_valid_d;
  logic [INSTR_WIDTH-1:0]   out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0]    out_pc_q, out_pc_d;

  logic                     issue_ok;
  logic                     icache_req;

  // The output register is free, or is being drained this cycle.
  assign issue_ok = !out_valid_q || in_ready;

  // Gated by rst_n so no request is seen by the cache while reset is held.
  assign icache_req = rst_n && (state_q == StIssue) && issue_ok && !in_redirect_valid;

  assign out_icache_req  = icache_req;
  assign out_icache_addr = pc_q;
  assign out_valid       = out_valid_q;
  assign out_instr       = out_instr_q;
  assign out_pc          = out_pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    if (out_valid_q && in_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_redirect_valid) begin
      pc_d        = in_redirect_addr;
      out_valid_d = 1'b0;
      if (state_q == StWait) begin
        if (in_icache_valid) begin
          // The response returned this cycle belongs to the old path: drop it.
          state_d   = StIssue;
          discard_d = 1'b0;
        end else begin
          // The response is still outstanding: remember to drop it on arrival.
          discard_d = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        StIssue: begin
          if (icache_req) begin
            state_d = StWait;
          end
        end
        StWait: begin
          if (in_icache_valid) begin
            state_d = StIssue;
            if (discard_q) begin
              // pc already holds the redirect target.
              discard_d = 1'b0;
            end else begin
              out_valid_d = 1'b1;
              out_instr_d = in_icache_instr;
              out_pc_d    = pc_q;
              pc_d        = pc_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = StIssue;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIssue;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

endmodule

// File: tb/tb_snow64_instr_fetch.sv
// Self-checking bench for snow64_instr_fetch. A behavioural cache drives the
// fetch stage. A transaction-level reference model predicts the request stream
// and the instruction stream that decode should see.
module tb_snow64_instr_fetch;

  localparam int unsigned AW  = 64;
  localparam int unsigned IW  = 32;
  localparam logic [AW-1:0] RPC = 64'h100;

  logic          clk;
  logic          rst_n;
  logic          out_icache_req;
  logic [AW-1:0] out_icache_addr;
  logic          in_icache_valid;
  logic [IW-1:0] in_icache_instr;
  logic          in_redirect_valid;
  logic [AW-1:0] in_redirect_addr;
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          in_ready;

  snow64_instr_fetch #(
    .ADDR_WIDTH  (AW),
    .INSTR_WIDTH (IW),
    .RESET_PC    (RPC)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .out_icache_req    (out_icache_req),
    .out_icache_addr   (out_icache_addr),
    .in_icache_valid   (in_icache_valid),
    .in_icache_instr   (in_icache_instr),
    .in_redirect_valid (in_redirect_valid),
    .in_redirect_addr  (in_redirect_addr),
    .out_valid         (out_valid),
    .out_instr         (out_instr),
    .out_pc            (out_pc),
    .in_ready          (in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: what decode should hold, and what the cache owes us.
  logic          m_valid;
  logic [AW-1:0] m_pc;
  logic [IW-1:0] m_instr;
  logic          m_outst;     // a request is outstanding at the cache
  logic          m_stale;     // that outstanding response belongs to an old path
  logic [AW-1:0] m_pend;      // address of the outstanding request
  logic [AW-1:0] m_next_req;  // address the next request must target

  // Behavioural cache and stimulus knobs.
  int            c_cnt;
  logic [IW-1:0] c_data;
  logic          s_req;
  logic [AW-1:0] s_addr;
  int            ready_pct, miss_pct, redir_pct;
  int            force_lat;
  logic          force_data_en;
  logic [IW-1:0] force_data;
  logic          dir_redir;
  logic [AW-1:0] dir_target;
  logic          redir_on_resp;
  int            cyc;
  int            rq_cyc[$];
  logic [AW-1:0] rq_addr[$];
  logic          seen_dead, seen_20, seen_400, seen_zero;

  function automatic logic [IW-1:0] hit_data(input logic [AW-1:0] a);
    return 32'hA000_0000 + a[31:0];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_instr = '0;
    m_outst = 1'b0; m_stale = 1'b0; m_pend = '0; m_next_req = RPC;
    c_cnt = 0; c_data = '0; s_req = 1'b0;
    in_icache_valid = 1'b0; in_icache_instr = '0;
    in_redirect_valid = 1'b0; in_redirect_addr = '0;
    in_ready = 1'b1; force_lat = -1; force_data_en = 1'b0;
    dir_redir = 1'b0; redir_on_resp = 1'b0;
  endtask

  task automatic drive();
    int lat;
    logic [IW-1:0] d;
    if (s_req) begin
      if (force_lat >= 0) lat = force_lat;
      else lat = ($urandom_range(99) < miss_pct) ? $urandom_range(5, 1) : 0;
      d = force_data_en ? force_data : hit_data(s_addr);
      force_lat = -1; force_data_en = 1'b0;
      c_data = d; c_cnt = lat;
      in_icache_valid = (lat == 0);
      in_icache_instr = (lat == 0) ? d : $urandom();
    end else if (c_cnt > 0) begin
      c_cnt--;
      in_icache_valid = (c_cnt == 0);
      in_icache_instr = (c_cnt == 0) ? c_data : $urandom();
    end
    in_ready = ($urandom_range(99) < ready_pct);
    in_redirect_valid = 1'b0;
    in_redirect_addr = {$urandom(), $urandom()};
    if (dir_redir) begin
      in_redirect_valid = 1'b1; in_redirect_addr = dir_target; dir_redir = 1'b0;
    end else if (redir_on_resp && in_icache_valid && m_outst) begin
      in_redirect_valid = 1'b1; in_redirect_addr = 64'h80; redir_on_resp = 1'b0;
    end else if ($urandom_range(99) < redir_pct) begin
      in_redirect_valid = 1'b1;
      if ($urandom_range(3) == 0) in_redirect_addr = 64'hFFFF_FFFF_FFFF_FFFE;
    end
  endtask

  // One clock cycle: sample and check at the falling edge, advance the model
  // across the rising edge, then drive the next cycle's inputs.
  task automatic cycle();
    logic e_req, xfer, resp;
    @(negedge clk);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_pc", out_pc, m_pc);
      check("out_instr", out_instr, m_instr);
    end
    e_req = !m_outst && (!m_valid || in_ready) && !in_redirect_valid;
    check("icache_req", out_icache_req, e_req);
    if (out_icache_req) begin
      check("icache_addr", out_icache_addr, m_next_req);
      rq_cyc.push_back(cyc);
      rq_addr.push_back(out_icache_addr);
      if (out_icache_addr == '0) seen_zero = 1'b1;
    end
    if (out_valid && in_ready) begin
      if (out_pc == 64'h108 && out_instr == 32'hDEAD_BEEF) seen_dead = 1'b1;
      if (out_pc == 64'h20) seen_20 = 1'b1;
      if (out_pc == 64'h400) seen_400 = 1'b1;
    end

    xfer = m_valid && in_ready;
    resp = m_outst && in_icache_valid;
    if (in_redirect_valid) begin
      m_valid = 1'b0;
      m_next_req = in_redirect_addr;
      if (m_outst) begin
        if (in_icache_valid) begin
          m_outst = 1'b0; m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else begin
      if (xfer) m_valid = 1'b0;
      if (resp) begin
        m_outst = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else begin
          m_valid = 1'b1; m_pc = m_pend; m_instr = in_icache_instr;
        end
      end
    end
    if (out_icache_req) begin
      m_outst = 1'b1; m_pend = m_next_req; m_next_req = m_next_req + 1;
    end
    s_req = out_icache_req;
    s_addr = out_icache_addr;

    @(posedge clk);
    #1;
    drive();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect_to(input logic [AW-1:0] a);
    dir_redir = 1'b1; dir_target = a;
    cycle();
  endtask

  task automatic run_until_wait(input logic [AW-1:0] a);
    int n = 0;
    while (!(m_outst && m_pend == a && !in_icache_valid) && n < 40) begin
      cycle(); n++;
    end
    check("wait_reached", (n < 40), 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_icache_req", out_icache_req, 0);
    check("rst_icache_addr", out_icache_addr, RPC);
  endtask

  initial begin
    rst_n = 1'b1;
    model_reset();
    ready_pct = 100; miss_pct = 0; redir_pct = 0;
    seen_dead = 1'b0; seen_20 = 1'b0; seen_400 = 1'b0; seen_zero = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;

    // Steady hits from reset: requests on cycles 0, 2, 4.
    run(10);
    check("req_count_ok", (rq_addr.size() >= 3), 1);
    if (rq_addr.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check("steady_req_addr", rq_addr[i], RPC + 64'(i));
        check("steady_req_cycle", 64'(rq_cyc[i]), 64'(2 * i));
      end
    end

    // Miss latency at 0x108.
    redirect_to(64'h108);
    force_lat = 5; force_data_en = 1'b1; force_data = 32'hDEAD_BEEF;
    run(15);
    check("miss_deadbeef_seen", seen_dead, 1);

    // Backpressure: decode stalls while an instruction is held.
    ready_pct = 0;
    run(8);
    ready_pct = 100;
    run(4);

    // Redirect during a miss: the 0x20 response must never reach decode.
    redirect_to(64'h20);
    force_lat = 8;
    run_until_wait(64'h20);
    seen_20 = 1'b0; seen_400 = 1'b0;
    redirect_to(64'h400);
    run(20);
    check("stale_0x20_dropped", seen_20, 0);
    check("redirect_0x400_seen", seen_400, 1);

    // Redirect coincident with a returning hit.
    redir_on_resp = 1'b1;
    run(12);
    check("coincident_fired", redir_on_resp, 0);

    // PC wrap.
    seen_zero = 1'b0;
    redirect_to(64'hFFFF_FFFF_FFFF_FFFF);
    run(8);
    check("wrap_req_zero", seen_zero, 1);

    // Asynchronous reset in the middle of a miss.
    redirect_to(64'h300);
    force_lat = 20;
    run_until_wait(64'h300);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(6);

    // Randomized traffic with misses, stalls and redirects.
    ready_pct = 70; miss_pct = 30; redir_pct = 5;
    run(3000);
    ready_pct = 100; miss_pct = 0; redir_pct = 0;
    run(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
